// File: rtl/serial_to_parallel_n_if.sv
// serial_to_parallel_n_if: narrow input stream and wide packed output stream of the packer
interface serial_to_parallel_n_if #(
  parameter int DATA_W = 32,
  parameter int RATIO  = 2
);
  localparam int CNT_W = $clog2(RATIO + 1);
  logic [DATA_W-1:0]       i_data;
  logic                    i_valid;
  logic                    i_last;
  logic                    i_ready;
  logic [DATA_W*RATIO-1:0] o_data;
  logic                    o_valid;
  logic [CNT_W-1:0]        o_count;
  logic                    o_last;
  logic                    o_ready;
  modport master (
    output i_data, i_valid, i_last, o_ready,
    input  i_ready, o_data, o_valid, o_count, o_last
  );
  modport slave (
    input  i_data, i_valid, i_last, o_ready,
    output i_ready, o_data, o_valid, o_count, o_last
  );
endinterface

// File: rtl/serial_to_parallel_n.sv
// serial_to_parallel_n: packs RATIO narrow words into one wide word with backpressure and frame flush
module serial_to_parallel_n #(
  parameter int DATA_W = 32,
  parameter int RATIO  = 2,
  parameter int ORDER  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  serial_to_parallel_n_if.slave s
);
  localparam int CNT_W = $clog2(RATIO + 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d, count_q, count_d;
  logic [DATA_W*RATIO-1:0] buf_q, buf_d, data_q, data_d, packed_w;
  logic                    valid_q, valid_d, last_q, last_d;
  logic                    accept, complete;
  int                      idx;
  assign s.i_ready = !valid_q || s.o_ready;
  assign s.o_data  = data_q;
  assign s.o_valid = valid_q;
  assign s.o_count = count_q;
  assign s.o_last  = last_q;
  // merge the incoming word into its slice and decide the next packer/output state
  always_comb begin
    accept   = s.i_valid && s.i_ready;
    complete = accept && (cnt_q == CNT_W'(RATIO - 1) || s.i_last);
    idx      = (ORDER != 0) ? int'(cnt_q) : RATIO - 1 - int'(cnt_q);
    packed_w = buf_q;
    for (int j = 0; j < RATIO; j++)
      if (j == idx) packed_w[j*DATA_W +: DATA_W] = s.i_data;
    cnt_d    = (clear || complete) ? '0 : accept ? cnt_q + CNT_W'(1) : cnt_q;
    buf_d    = (clear || complete) ? '0 : accept ? packed_w : buf_q;
    valid_d  = clear ? 1'b0 : complete ? 1'b1 : (valid_q && s.o_ready) ? 1'b0 : valid_q;
    data_d   = clear ? '0 : complete ? packed_w : data_q;
    count_d  = clear ? '0 : complete ? cnt_q + CNT_W'(1) : count_q;
    last_d   = clear ? 1'b0 : complete ? s.i_last : last_q;
  end
  // state registers, cleared asynchronously by active-low rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_serial_to_parallel_n.sv
// tb_serial_to_parallel_n: directed checks of packing, order, flush, backpressure, clear and reset
module tb_serial_to_parallel_n;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  serial_to_parallel_n_if #(.DATA_W(8),  .RATIO(4)) a ();
  serial_to_parallel_n_if #(.DATA_W(8),  .RATIO(4)) b ();
  serial_to_parallel_n_if #(.DATA_W(32), .RATIO(2)) c ();
  serial_to_parallel_n #(.DATA_W(8),  .RATIO(4), .ORDER(0)) u_a (.clk(clk), .rst(rst), .clear(clear), .s(a));
  serial_to_parallel_n #(.DATA_W(8),  .RATIO(4), .ORDER(1)) u_b (.clk(clk), .rst(rst), .clear(clear), .s(b));
  serial_to_parallel_n #(.DATA_W(32), .RATIO(2), .ORDER(0)) u_c (.clk(clk), .rst(rst), .clear(clear), .s(c));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_a(input logic [7:0] d, input logic l);
    a.i_data = d;
    a.i_valid = 1'b1;
    a.i_last = l;
    step();
    a.i_valid = 1'b0;
    a.i_last = 1'b0;
  endtask
  task automatic test_reset();
    a.i_valid = 0; a.i_last = 0; a.i_data = 0; a.o_ready = 1;
    b.i_valid = 0; b.i_last = 0; b.i_data = 0; b.o_ready = 1;
    c.i_valid = 0; c.i_last = 0; c.i_data = 0; c.o_ready = 1;
    step();
    n_checks++;
    if ({a.o_valid, a.o_last, a.o_count, a.o_data} !== 39'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {a.o_valid, a.o_last, a.o_count, a.o_data});
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (a.i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %b want 1", a.i_ready); end
  endtask
  task automatic test_pack_msb_first();
    for (int i = 1; i <= 4; i++) drive_a(8'(i), 1'b0);
    n_checks++;
    if (a.o_valid !== 1'b1 || a.o_data !== 32'h01020304 || a.o_count !== 3'd4 || a.o_last !== 1'b0) begin
      n_fail++;
      $display("FAIL pack_order0: got v=%b d=%h n=%0d l=%b want v=1 d=01020304 n=4 l=0", a.o_valid, a.o_data, a.o_count, a.o_last);
    end
    step();
    n_checks++;
    if (a.o_valid !== 1'b0) begin n_fail++; $display("FAIL pack_order0_drop: got o_valid=%b want 0", a.o_valid); end
  endtask
  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      b.i_data = 8'(i);
      b.i_valid = 1'b1;
      n_checks++;
      if (b.i_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_i_ready word %0d: got %b want 1", i, b.i_ready); end
      step();
      if (i == 4) begin
        n_checks++;
        if (b.o_valid !== 1'b1 || b.o_data !== 32'h04030201) begin
          n_fail++;
          $display("FAIL b2b_group0: got v=%b d=%h want v=1 d=04030201", b.o_valid, b.o_data);
        end
      end
      if (i == 8) begin
        n_checks++;
        if (b.o_valid !== 1'b1 || b.o_data !== 32'h08070605) begin
          n_fail++;
          $display("FAIL b2b_group1: got v=%b d=%h want v=1 d=08070605", b.o_valid, b.o_data);
        end
      end
    end
    b.i_valid = 1'b0;
  endtask
  task automatic test_last_flush();
    drive_a(8'h0A, 1'b0);
    drive_a(8'h0B, 1'b1);
    n_checks++;
    if (a.o_valid !== 1'b1 || a.o_data !== 32'h0A0B0000 || a.o_count !== 3'd2 || a.o_last !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_partial: got v=%b d=%h n=%0d l=%b want v=1 d=0a0b0000 n=2 l=1", a.o_valid, a.o_data, a.o_count, a.o_last);
    end
    drive_a(8'h11, 1'b0);
    drive_a(8'h22, 1'b0);
    drive_a(8'h33, 1'b0);
    drive_a(8'h44, 1'b1);
    n_checks++;
    if (a.o_data !== 32'h11223344 || a.o_count !== 3'd4 || a.o_last !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full_last: got d=%h n=%0d l=%b want d=11223344 n=4 l=1", a.o_data, a.o_count, a.o_last);
    end
    drive_a(8'h55, 1'b1);
    n_checks++;
    if (a.o_data !== 32'h55000000 || a.o_count !== 3'd1 || a.o_last !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_single: got d=%h n=%0d l=%b want d=55000000 n=1 l=1", a.o_data, a.o_count, a.o_last);
    end
    step();
  endtask
  task automatic test_backpressure();
    a.o_ready = 1'b0;
    for (int i = 1; i <= 4; i++) drive_a(8'(i), 1'b0);
    a.i_data = 8'h99;
    a.i_valid = 1'b1;
    step(); step(); step();
    n_checks++;
    if (a.o_valid !== 1'b1 || a.o_data !== 32'h01020304 || a.o_count !== 3'd4 || a.i_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%b d=%h n=%0d rdy=%b want v=1 d=01020304 n=4 rdy=0", a.o_valid, a.o_data, a.o_count, a.i_ready);
    end
    a.i_valid = 1'b0;
    a.o_ready = 1'b1;
    #1;
    n_checks++;
    if (a.i_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", a.i_ready); end
    step();
    n_checks++;
    if (a.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got o_valid=%b want 0", a.o_valid); end
    for (int i = 5; i <= 8; i++) drive_a(8'(i), 1'b0);
    n_checks++;
    if (a.o_data !== 32'h05060708) begin n_fail++; $display("FAIL bp_no_consume: got %h want 05060708", a.o_data); end
    step();
  endtask
  task automatic test_clear();
    drive_a(8'h01, 1'b0);
    drive_a(8'h02, 1'b0);
    a.i_data = 8'h03;
    a.i_valid = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    a.i_valid = 1'b0;
    n_checks++;
    if (a.o_valid !== 1'b0) begin n_fail++; $display("FAIL clear_no_output: got o_valid=%b want 0", a.o_valid); end
    for (int i = 0; i < 4; i++) drive_a(8'hA1 + 8'(i), 1'b0);
    n_checks++;
    if (a.o_valid !== 1'b1 || a.o_data !== 32'hA1A2A3A4 || a.o_count !== 3'd4) begin
      n_fail++;
      $display("FAIL clear_clean_group: got v=%b d=%h n=%0d want v=1 d=a1a2a3a4 n=4", a.o_valid, a.o_data, a.o_count);
    end
    a.o_ready = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    a.o_ready = 1'b1;
    n_checks++;
    if (a.o_valid !== 1'b0 || a.o_count !== 3'd0 || a.o_last !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_pending: got v=%b n=%0d l=%b want v=0 n=0 l=0", a.o_valid, a.o_count, a.o_last);
    end
  endtask
  task automatic test_async_reset();
    c.o_ready = 1'b0;
    c.i_valid = 1'b1;
    c.i_data = 32'h1111_1111;
    step();
    c.i_data = 32'h2222_2222;
    step();
    c.i_valid = 1'b0;
    drive_a(8'h01, 1'b0);
    drive_a(8'h02, 1'b0);
    n_checks++;
    if (c.o_valid !== 1'b1 || c.o_data !== 64'h1111_1111_2222_2222) begin
      n_fail++;
      $display("FAIL pre_reset_held: got v=%b d=%h want v=1 d=1111111122222222", c.o_valid, c.o_data);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (c.o_valid !== 1'b0 || c.o_data !== 64'h0 || c.o_count !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b d=%h n=%0d want all 0", c.o_valid, c.o_data, c.o_count);
    end
    step();
    rst = 1'b1;
    c.o_ready = 1'b1;
    step();
    c.i_valid = 1'b1;
    c.i_data = 32'hDEADBEEF;
    step();
    c.i_data = 32'h12345678;
    step();
    c.i_valid = 1'b0;
    n_checks++;
    if (c.o_valid !== 1'b1 || c.o_data !== 64'hDEADBEEF_12345678 || c.o_count !== 2'd2) begin
      n_fail++;
      $display("FAIL legacy_pair: got v=%b d=%h n=%0d want v=1 d=deadbeef12345678 n=2", c.o_valid, c.o_data, c.o_count);
    end
    for (int i = 0; i < 4; i++) drive_a(8'hC1 + 8'(i), 1'b0);
    n_checks++;
    if (a.o_data !== 32'hC1C2C3C4) begin n_fail++; $display("FAIL reset_no_residue: got %h want c1c2c3c4", a.o_data); end
  endtask
  initial begin
    test_reset();
    test_pack_msb_first();
    test_back_to_back();
    test_last_flush();
    test_backpressure();
    test_clear();
    test_async_reset();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
